alu_unit: RTL and testbench

Parameterised two-operand integer ALU (default 4-bit) performing add/subtract with carry-in, bitwise logic, and signed/equality compare. Results and status flags are registered. The unit is the arithmetic core of the datapath; the surrounding logic supplies `op` and the operands every cycle.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_addsub.sv | 28 ++
 rtl/alu_unit.sv | 90 +++++++++
 tb/tb_alu_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op-code enum and default width shared by the ALU files
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - WIDTH-bit adder with optional Y/carry inversion for subtract
// Carry out is the raw adder carry; the caller turns it into a borrow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] y_eff;
  logic             c_eff;

  assign y_eff = sub_i ? ~y_i : y_i;
  assign c_eff = sub_i ? ~cin_i : cin_i;

  assign {cout_o, sum_o} = {1'b0, x_i} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};

  // Signed overflow of the actual addition performed, valid for both add and subtract.
  assign ovf_o = (x_i[WIDTH-1] == y_eff[WIDTH-1]) && (sum_o[WIDTH-1] != x_i[WIDTH-1]);

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered two-operand ALU: op decode, zero detect, output stage
// ALU_CMP_EN enables the SLT/EQ comparators; without it those ops return zero.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow
);

  logic             as_sub;
  logic             as_cin;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;

`ifdef ALU_CMP_EN
  // SLT reuses the subtractor with the borrow-in forced low.
  assign as_sub = (op == OP_SUB) || (op == OP_SLT);
  assign as_cin = (op == OP_SLT) ? 1'b0 : in_c;
`else
  assign as_sub = (op == OP_SUB);
  assign as_cin = in_c;
`endif

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x_i    (in_x),
    .y_i    (in_y),
    .cin_i  (as_cin),
    .sub_i  (as_sub),
    .sum_o  (as_sum),
    .cout_o (as_cout),
    .ovf_o  (as_ovf)
  );

  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  always_comb begin
    s_d   = '0;
    c_d   = 1'b0;
    ovf_d = 1'b0;
    case (op_e'(op))
      OP_ADD: begin s_d = as_sum; c_d = as_cout;  ovf_d = as_ovf; end
      OP_SUB: begin s_d = as_sum; c_d = ~as_cout; ovf_d = as_ovf; end
      OP_NOT: s_d = ~in_x;
      OP_AND: s_d = in_x & in_y;
      OP_OR:  s_d = in_x | in_y;
      OP_XOR: s_d = in_x ^ in_y;
`ifdef ALU_CMP_EN
      // Sign XOR overflow gives the true signed less-than even when X-Y wraps.
      OP_SLT: s_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      OP_EQ:  s_d = {{(WIDTH-1){1'b0}}, (in_x == in_y)};
`endif
      default: s_d = '0;
    endcase
    zero_d = (s_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      c_q    <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      s_q    <= s_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_s    = s_q;
  assign out_c    = c_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit (WIDTH=4), honours ALU_CMP_EN
module tb_alu_unit;
  import alu_pkg::*;

  localparam int W = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   op = 3'b000;
  logic         in_c = 1'b0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic [W-1:0] out_s;
  logic         out_c, zero, overflow;

  int errors = 0;
  int checks = 0;

  alu_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .in_c     (in_c),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_s    (out_s),
    .out_c    (out_c),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic         c;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] o, logic c, logic [W-1:0] x, logic [W-1:0] y,
                              logic [W-1:0] s, logic co, logic ov, logic z);
    vec_t v;
    v.op = o; v.c = c; v.x = x; v.y = y; v.s = s; v.co = co; v.ov = ov; v.z = z;
    return v;
  endfunction

  function automatic int sgn(logic [W-1:0] v);
    return v[W-1] ? int'(v) - M : int'(v);
  endfunction

  // Reference model from plain integer arithmetic on unsigned and signed views.
  function automatic vec_t model(logic [2:0] o, logic c, logic [W-1:0] x, logic [W-1:0] y);
    vec_t r;
    int u, sr;
    r = mk(o, c, x, y, '0, 1'b0, 1'b0, 1'b0);
    case (o)
      3'd0: begin
        u  = int'(x) + int'(y) + int'(c);
        sr = sgn(x) + sgn(y) + int'(c);
        r.s = W'(u % M); r.co = (u >= M); r.ov = (sr > M/2 - 1) || (sr < -M/2);
      end
      3'd1: begin
        u  = int'(x) - int'(y) - int'(c);
        sr = sgn(x) - sgn(y) - int'(c);
        r.s = W'((u + 2*M) % M); r.co = (u < 0); r.ov = (sr > M/2 - 1) || (sr < -M/2);
      end
      3'd2: r.s = W'(M - 1 - int'(x));
      3'd3: r.s = x & y;
      3'd4: r.s = x | y;
      3'd5: r.s = x ^ y;
`ifdef ALU_CMP_EN
      3'd6: r.s = (sgn(x) < sgn(y)) ? W'(1) : W'(0);
      3'd7: r.s = (x == y) ? W'(1) : W'(0);
`endif
      default: r.s = '0;
    endcase
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: op=%0d c=%0d x=%h y=%h got=%0h expected=%0h",
               name, op, in_c, in_x, in_y, got, exp);
    end
  endtask

  task automatic check_all(string tag, vec_t e);
    check({tag, ".out_s"},    int'(out_s),    int'(e.s));
    check({tag, ".out_c"},    int'(out_c),    int'(e.co));
    check({tag, ".overflow"}, int'(overflow), int'(e.ov));
    check({tag, ".zero"},     int'(zero),     int'(e.z));
  endtask

  task automatic drive(logic [2:0] o, logic c, logic [W-1:0] x, logic [W-1:0] y);
    @(negedge clk);
    op = o; in_c = c; in_x = x; in_y = y;
    @(posedge clk);
    #1;
  endtask

  vec_t reset_v;

  initial begin
    reset_v = mk(3'd0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

    vecs.push_back(mk(OP_ADD, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(OP_ADD, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(OP_ADD, 1'b1, 4'b0001, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SUB, 1'b0, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SUB, 1'b0, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(OP_SUB, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(OP_AND, 1'b1, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_OR,  1'b1, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_XOR, 1'b0, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_NOT, 1'b1, 4'b1100, 4'b1010, 4'b0011, 1'b0, 1'b0, 1'b0));
`ifdef ALU_CMP_EN
    vecs.push_back(mk(OP_SLT, 1'b1, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_SLT, 1'b0, 4'b0111, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(OP_EQ,  1'b0, 4'b1010, 4'b1010, 4'b0001, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_EQ,  1'b1, 4'b1010, 4'b1011, 4'b0000, 1'b0, 1'b0, 1'b1));
`else
    vecs.push_back(mk(OP_SLT, 1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(OP_EQ,  1'b0, 4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b1));
`endif

    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", reset_v);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].c, vecs[i].x, vecs[i].y);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    for (int o = 0; o < 8; o++)
      for (int x = 0; x < M; x++)
        for (int y = 0; y < M; y++) begin
          logic c;
          c = 1'($urandom_range(0, 1));
          drive(3'(o), c, W'(x), W'(y));
          check_all($sformatf("sweep_op%0d", o), model(3'(o), c, W'(x), W'(y)));
        end

    for (int k = 0; k < 300; k++) begin
      logic [2:0]   o;
      logic         c;
      logic [W-1:0] x, y;
      o = 3'($urandom); c = 1'($urandom); x = W'($urandom); y = W'($urandom);
      drive(o, c, x, y);
      check_all("random", model(o, c, x, y));
    end

    // Async reset between edges: outputs clear before any clock edge.
    drive(OP_ADD, 1'b0, 4'b0111, 4'b0111);
    check_all("pre_rst", model(OP_ADD, 1'b0, 4'b0111, 4'b0111));
    #2 rst = 1'b1;
    #1 check_all("async_rst", reset_v);
    @(negedge clk);
    op = OP_OR; in_x = 4'b0101; in_y = 4'b0010;
    @(posedge clk); #1;
    check_all("rst_held", reset_v);
    @(negedge clk) rst = 1'b0;
    #1 check_all("rst_release", reset_v);
    @(posedge clk); #1;
    check_all("first_after_rst", model(OP_OR, 1'b0, 4'b0101, 4'b0010));

    // Input changes between edges must not reach the outputs.
    drive(OP_XOR, 1'b0, 4'b1111, 4'b0000);
    in_x = 4'b0000;
    #3 check_all("hold", model(OP_XOR, 1'b0, 4'b1111, 4'b0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
